// File: rtl/ddr_line_master.sv
// ddr_line_master
//   Bridges the data-cache refill/eviction path to a 128-bit AXI4 memory
//   port. One 16-byte line write and one 16-byte line read can be in
//   flight at the same time. Each is issued as a single-beat INCR burst.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   wr_addr/wr_data      line write request payload, latched on accept
//   wr_valid/wr_ready    write request handshake (wr_ready = channel idle)
//   rd_addr              line read request address, latched on accept
//   rd_avalid/rd_aready  read request handshake (rd_aready = channel idle
//                        and no undelivered line pending)
//   rd_data/rd_valid     returned line, held until rd_dready
//   rd_dready            consumer accepts rd_data
//   M_AXI_AW*/W*/B*      AXI4 write address, data and response channels
//   M_AXI_AR*/R*         AXI4 read address and data channels
//
// Configuration
//   DDR_MASTER_RETRY_EN  when defined, a non-OKAY BRESP/RRESP reissues the
//                        same transaction; otherwise responses are ignored.
//
// All outputs are registered.

module ddr_line_master (
  input  logic         clk,
  input  logic         rst,
  input  logic [26:0]  wr_addr,
  input  logic [127:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [26:0]  rd_addr,
  input  logic         rd_avalid,
  output logic         rd_aready,
  output logic [127:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_dready,
  output logic [26:0]  M_AXI_AWADDR,
  output logic [7:0]   M_AXI_AWLEN,
  output logic [2:0]   M_AXI_AWSIZE,
  output logic [1:0]   M_AXI_AWBURST,
  output logic         M_AXI_AWLOCK,
  output logic [3:0]   M_AXI_AWCACHE,
  output logic [2:0]   M_AXI_AWPROT,
  output logic [3:0]   M_AXI_AWQOS,
  output logic         M_AXI_AWVALID,
  input  logic         M_AXI_AWREADY,
  output logic [127:0] M_AXI_WDATA,
  output logic [15:0]  M_AXI_WSTRB,
  output logic         M_AXI_WLAST,
  output logic         M_AXI_WVALID,
  input  logic         M_AXI_WREADY,
  input  logic [1:0]   M_AXI_BRESP,
  input  logic         M_AXI_BVALID,
  output logic         M_AXI_BREADY,
  output logic [26:0]  M_AXI_ARADDR,
  output logic [7:0]   M_AXI_ARLEN,
  output logic [2:0]   M_AXI_ARSIZE,
  output logic [1:0]   M_AXI_ARBURST,
  output logic [1:0]   M_AXI_ARLOCK,
  output logic [3:0]   M_AXI_ARCACHE,
  output logic [2:0]   M_AXI_ARPROT,
  output logic [3:0]   M_AXI_ARQOS,
  output logic         M_AXI_ARVALID,
  input  logic         M_AXI_ARREADY,
  input  logic [127:0] M_AXI_RDATA,
  input  logic [1:0]   M_AXI_RRESP,
  input  logic         M_AXI_RLAST,
  input  logic         M_AXI_RVALID,
  output logic         M_AXI_RREADY
);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic aw_vld_next;
  logic w_vld_next;
  logic rd_vld_next;
  logic rd_capture;
  logic w_bad_resp;
  logic r_bad_resp;

  // Single-beat, full-line, cacheable-bufferable bursts only.
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b100;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_WSTRB   = 16'hFFFF;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b100;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 2'b00;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'd0;

`ifdef DDR_MASTER_RETRY_EN
  assign w_bad_resp = (M_AXI_BRESP != 2'b00);
  assign r_bad_resp = (M_AXI_RRESP != 2'b00);
`else
  logic unused_resp;
  assign unused_resp = ^{M_AXI_BRESP, M_AXI_RRESP};
  assign w_bad_resp  = 1'b0;
  assign r_bad_resp  = 1'b0;
`endif

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // AWVALID and WVALID retire independently; W_RESP is entered once both
  // have handshaken, whichever order that happens in.
  always_comb begin
    w_next      = w_state;
    aw_vld_next = M_AXI_AWVALID;
    w_vld_next  = M_AXI_WVALID;
    case (w_state)
      W_IDLE: begin
        if (wr_valid) begin
          w_next      = W_SEND;
          aw_vld_next = 1'b1;
          w_vld_next  = 1'b1;
        end
      end
      W_SEND: begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_vld_next = 1'b0;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_vld_next  = 1'b0;
        if (!aw_vld_next && !w_vld_next)    w_next      = W_RESP;
      end
      W_RESP: begin
        if (M_AXI_BVALID) begin
          if (w_bad_resp) begin
            w_next      = W_SEND;
            aw_vld_next = 1'b1;
            w_vld_next  = 1'b1;
          end else begin
            w_next = W_IDLE;
          end
        end
      end
      default: begin
        w_next      = W_IDLE;
        aw_vld_next = 1'b0;
        w_vld_next  = 1'b0;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so wr_ready drops
  // right after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ready      <= 1'b1;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_AWADDR  <= 27'd0;
      M_AXI_WDATA   <= 128'd0;
    end else begin
      wr_ready      <= (w_next == W_IDLE);
      M_AXI_AWVALID <= aw_vld_next;
      M_AXI_WVALID  <= w_vld_next;
      M_AXI_BREADY  <= (w_next == W_RESP);
      if (w_state == W_IDLE && wr_valid) begin
        M_AXI_AWADDR <= wr_addr;
        M_AXI_WDATA  <= wr_data;
      end
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // A beat without RLAST is consumed and dropped; only the last beat is
  // delivered to the cache.
  always_comb begin
    r_next      = r_state;
    rd_vld_next = rd_valid && !rd_dready;
    rd_capture  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (rd_avalid && rd_aready) r_next = R_ADDR;
      end
      R_ADDR: begin
        if (M_AXI_ARREADY) r_next = R_DATA;
      end
      R_DATA: begin
        if (M_AXI_RVALID && M_AXI_RLAST) begin
          if (r_bad_resp) begin
            r_next = R_ADDR;
          end else begin
            r_next      = R_IDLE;
            rd_capture  = 1'b1;
            rd_vld_next = 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_aready     <= 1'b1;
      rd_valid      <= 1'b0;
      rd_data       <= 128'd0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_ARADDR  <= 27'd0;
    end else begin
      rd_aready     <= (r_next == R_IDLE) && !rd_vld_next;
      rd_valid      <= rd_vld_next;
      M_AXI_ARVALID <= (r_next == R_ADDR);
      M_AXI_RREADY  <= (r_next == R_DATA);
      if (rd_capture)
        rd_data <= M_AXI_RDATA;
      if (rd_avalid && rd_aready)
        M_AXI_ARADDR <= rd_addr;
    end
  end

endmodule

// File: tb/tb_ddr_line_master.sv
// Directed testbench for ddr_line_master. The bench plays the AXI slave
// cycle by cycle; inputs are changed and outputs sampled 1 ns after each
// rising edge.
module tb_ddr_line_master;

  logic         clk = 1'b0;
  logic         rst;
  logic [26:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic [26:0]  rd_addr;
  logic         rd_avalid;
  logic         rd_aready;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         rd_dready;
  logic [26:0]  M_AXI_AWADDR;
  logic [7:0]   M_AXI_AWLEN;
  logic [2:0]   M_AXI_AWSIZE;
  logic [1:0]   M_AXI_AWBURST;
  logic         M_AXI_AWLOCK;
  logic [3:0]   M_AXI_AWCACHE;
  logic [2:0]   M_AXI_AWPROT;
  logic [3:0]   M_AXI_AWQOS;
  logic         M_AXI_AWVALID;
  logic         M_AXI_AWREADY;
  logic [127:0] M_AXI_WDATA;
  logic [15:0]  M_AXI_WSTRB;
  logic         M_AXI_WLAST;
  logic         M_AXI_WVALID;
  logic         M_AXI_WREADY;
  logic [1:0]   M_AXI_BRESP;
  logic         M_AXI_BVALID;
  logic         M_AXI_BREADY;
  logic [26:0]  M_AXI_ARADDR;
  logic [7:0]   M_AXI_ARLEN;
  logic [2:0]   M_AXI_ARSIZE;
  logic [1:0]   M_AXI_ARBURST;
  logic [1:0]   M_AXI_ARLOCK;
  logic [3:0]   M_AXI_ARCACHE;
  logic [2:0]   M_AXI_ARPROT;
  logic [3:0]   M_AXI_ARQOS;
  logic         M_AXI_ARVALID;
  logic         M_AXI_ARREADY;
  logic [127:0] M_AXI_RDATA;
  logic [1:0]   M_AXI_RRESP;
  logic         M_AXI_RLAST;
  logic         M_AXI_RVALID;
  logic         M_AXI_RREADY;

  int n_cmp  = 0;
  int n_fail = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  int ar_cnt = 0;

  ddr_line_master dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_dready(rd_dready),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  // Handshake counters seen by the slave side.
  always @(posedge clk) begin
    if (!rst) begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
      if (M_AXI_WVALID && M_AXI_WREADY)   w_cnt  <= w_cnt + 1;
      if (M_AXI_ARVALID && M_AXI_ARREADY) ar_cnt <= ar_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_addr = '0; wr_data = '0; wr_valid = 1'b0;
    rd_addr = '0; rd_avalid = 1'b0; rd_dready = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (rd_aready !== 1'b1) begin n_fail++; $display("FAIL rst_rd_aready: got %b want 1", rd_aready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 128'd0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      n_fail++; $display("FAIL rst_valids: got %b want 00000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); end
    n_cmp++; if ({M_AXI_AWADDR, M_AXI_ARADDR} !== 54'd0) begin n_fail++; $display("FAIL rst_addrs: got %h %h want 0", M_AXI_AWADDR, M_AXI_ARADDR); end
    n_cmp++; if (M_AXI_WDATA !== 128'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", M_AXI_WDATA); end
    n_cmp++; if ({M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS}
                 !== {8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}) begin
      n_fail++; $display("FAIL aw_consts: got len=%h size=%b burst=%b lock=%b cache=%b prot=%b qos=%h",
        M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS); end
    n_cmp++; if ({M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS}
                 !== {8'd0, 3'b100, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0}) begin
      n_fail++; $display("FAIL ar_consts: got len=%h size=%b burst=%b lock=%b cache=%b prot=%b qos=%h",
        M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS); end
    n_cmp++; if ({M_AXI_WSTRB, M_AXI_WLAST} !== {16'hFFFF, 1'b1}) begin
      n_fail++; $display("FAIL w_consts: got strb=%h last=%b want FFFF 1", M_AXI_WSTRB, M_AXI_WLAST); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    int aw0, w0;
    logic [127:0] d;
    d = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDE01;
    aw0 = aw_cnt; w0 = w_cnt;
    wr_addr = 27'h0001230; wr_data = d; wr_valid = 1'b1;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    tick();  // accept edge
    wr_valid = 1'b0; wr_addr = 27'h7FFFFF0; wr_data = '1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_drop: got %b want 0", wr_ready); end
    n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11) begin n_fail++; $display("FAIL wr_aw_w_valid: got %b want 11", {M_AXI_AWVALID, M_AXI_WVALID}); end
    n_cmp++; if (M_AXI_AWADDR !== 27'h0001230) begin n_fail++; $display("FAIL wr_awaddr: got %h want 0001230", M_AXI_AWADDR); end
    n_cmp++; if (M_AXI_WDATA !== d) begin n_fail++; $display("FAIL wr_wdata: got %h want %h", M_AXI_WDATA, d); end
    tick();  // AW and W handshake together
    n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, wr_ready} !== 4'b0010) begin
      n_fail++; $display("FAIL wr_resp_state: got aw/w/b/rdy %b want 0010", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, wr_ready}); end
    n_cmp++; if (M_AXI_AWADDR !== 27'h0001230) begin n_fail++; $display("FAIL wr_awaddr_hold: got %h want 0001230", M_AXI_AWADDR); end
    M_AXI_BVALID = 1'b1;
    tick();
    M_AXI_BVALID = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    n_cmp++; if ({wr_ready, M_AXI_BREADY} !== 2'b10) begin n_fail++; $display("FAIL wr_done: got rdy/bready %b want 10", {wr_ready, M_AXI_BREADY}); end
    n_cmp++; if ((aw_cnt - aw0) !== 1 || (w_cnt - w0) !== 1) begin n_fail++; $display("FAIL wr_beats: got aw=%0d w=%0d want 1 1", aw_cnt - aw0, w_cnt - w0); end
  endtask

  task automatic test_read_zero_wait();
    logic [127:0] d;
    d = 128'h0123456789ABCDEF_0123456789ABCDEF;
    rd_addr = 27'h0004560; rd_avalid = 1'b1; rd_dready = 1'b1; M_AXI_ARREADY = 1'b1;
    tick();  // accept edge
    rd_avalid = 1'b0; rd_addr = 27'h1111110;
    n_cmp++; if ({rd_aready, M_AXI_ARVALID} !== 2'b01) begin n_fail++; $display("FAIL rd_c1: got aready/arvalid %b want 01", {rd_aready, M_AXI_ARVALID}); end
    n_cmp++; if (M_AXI_ARADDR !== 27'h0004560) begin n_fail++; $display("FAIL rd_araddr: got %h want 0004560", M_AXI_ARADDR); end
    tick();  // AR handshake
    n_cmp++; if ({M_AXI_ARVALID, M_AXI_RREADY, rd_valid} !== 3'b010) begin n_fail++; $display("FAIL rd_c2: got arvalid/rready/rd_valid %b want 010", {M_AXI_ARVALID, M_AXI_RREADY, rd_valid}); end
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; M_AXI_RDATA = d;
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RDATA = '0;
    n_cmp++; if ({rd_valid, rd_aready, M_AXI_RREADY} !== 3'b100) begin n_fail++; $display("FAIL rd_c3: got rd_valid/aready/rready %b want 100", {rd_valid, rd_aready, M_AXI_RREADY}); end
    n_cmp++; if (rd_data !== d) begin n_fail++; $display("FAIL rd_data: got %h want %h", rd_data, d); end
    tick();
    n_cmp++; if ({rd_valid, rd_aready} !== 2'b01) begin n_fail++; $display("FAIL rd_consumed: got rd_valid/aready %b want 01", {rd_valid, rd_aready}); end
    M_AXI_ARREADY = 1'b0;
  endtask

  task automatic test_concurrent();
    logic [127:0] d;
    d = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    wr_addr = 27'h10; wr_data = 128'h77; wr_valid = 1'b1;
    rd_addr = 27'h20; rd_avalid = 1'b1; rd_dready = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b1; M_AXI_ARREADY = 1'b1;
    tick();  // both accepted
    wr_valid = 1'b0; rd_avalid = 1'b0;
    n_cmp++; if ({wr_ready, rd_aready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID} !== 5'b00111) begin
      n_fail++; $display("FAIL cc_c1: got %b want 00111", {wr_ready, rd_aready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}); end
    n_cmp++; if ({M_AXI_AWADDR, M_AXI_ARADDR} !== {27'h10, 27'h20}) begin n_fail++; $display("FAIL cc_addrs: got %h %h want 10 20", M_AXI_AWADDR, M_AXI_ARADDR); end
    tick();  // W and AR handshake, AW stalled
    M_AXI_ARREADY = 1'b0;
    n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY} !== 3'b101) begin
      n_fail++; $display("FAIL cc_c2: got aw/w/rready %b want 101", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY}); end
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; M_AXI_RDATA = d;
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    n_cmp++; if ({rd_valid, M_AXI_AWVALID, M_AXI_BREADY} !== 3'b110) begin
      n_fail++; $display("FAIL cc_c3: got rd_valid/awvalid/bready %b want 110", {rd_valid, M_AXI_AWVALID, M_AXI_BREADY}); end
    n_cmp++; if (rd_data !== d) begin n_fail++; $display("FAIL cc_rd_data: got %h want %h", rd_data, d); end
    tick();
    n_cmp++; if ({rd_valid, rd_aready, M_AXI_AWVALID, wr_ready} !== 4'b1010) begin
      n_fail++; $display("FAIL cc_c4: got rd_valid/aready/awvalid/wr_ready %b want 1010", {rd_valid, rd_aready, M_AXI_AWVALID, wr_ready}); end
    M_AXI_AWREADY = 1'b1;
    tick();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    n_cmp++; if ({M_AXI_AWVALID, M_AXI_BREADY, wr_ready} !== 3'b010) begin
      n_fail++; $display("FAIL cc_c5: got awvalid/bready/wr_ready %b want 010", {M_AXI_AWVALID, M_AXI_BREADY, wr_ready}); end
    M_AXI_BVALID = 1'b1; rd_dready = 1'b1;
    tick();
    M_AXI_BVALID = 1'b0;
    n_cmp++; if ({wr_ready, rd_valid, rd_aready} !== 3'b101) begin
      n_fail++; $display("FAIL cc_c6: got wr_ready/rd_valid/aready %b want 101", {wr_ready, rd_valid, rd_aready}); end
  endtask

  task automatic test_backpressure();
    int aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    wr_addr = 27'h0ABCDE0; wr_data = 128'h55; wr_valid = 1'b1;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    tick();
    wr_valid = 1'b0;
    M_AXI_WREADY = 1'b1;
    tick();  // W handshake only
    M_AXI_WREADY = 1'b0;
    n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b100) begin
      n_fail++; $display("FAIL bp_w_first: got aw/w/bready %b want 100", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}); end
    tick();
    n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, wr_ready} !== 4'b1000) begin
      n_fail++; $display("FAIL bp_wait_aw: got aw/w/bready/wr_ready %b want 1000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, wr_ready}); end
    M_AXI_AWREADY = 1'b1;
    tick();
    M_AXI_AWREADY = 1'b0;
    n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b001) begin
      n_fail++; $display("FAIL bp_resp: got aw/w/bready %b want 001", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}); end
    M_AXI_BVALID = 1'b1;
    tick();
    M_AXI_BVALID = 1'b0;
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", wr_ready); end
    n_cmp++; if ((aw_cnt - aw0) !== 1 || (w_cnt - w0) !== 1) begin n_fail++; $display("FAIL bp_beats: got aw=%0d w=%0d want 1 1", aw_cnt - aw0, w_cnt - w0); end
  endtask

  task automatic test_reset_mid_read();
    logic [127:0] d;
    d = 128'hFEEDFACE_00000000_11111111_22222222;
    rd_addr = 27'h0003330; rd_avalid = 1'b1; rd_dready = 1'b1; M_AXI_ARREADY = 1'b1;
    tick();
    rd_avalid = 1'b0;
    tick();  // now in R_DATA
    n_cmp++; if (M_AXI_RREADY !== 1'b1) begin n_fail++; $display("FAIL rmr_in_data: got rready %b want 1", M_AXI_RREADY); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({M_AXI_ARVALID, M_AXI_RREADY, rd_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rd_aready, wr_ready} !== 8'b00000011) begin
      n_fail++; $display("FAIL rmr_after_rst: got %b want 00000011",
        {M_AXI_ARVALID, M_AXI_RREADY, rd_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rd_aready, wr_ready}); end
    rd_addr = 27'h0007770; rd_avalid = 1'b1;
    tick();
    rd_avalid = 1'b0;
    n_cmp++; if (M_AXI_ARADDR !== 27'h0007770) begin n_fail++; $display("FAIL rmr_araddr: got %h want 0007770", M_AXI_ARADDR); end
    tick();
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; M_AXI_RDATA = d;
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== d) begin n_fail++; $display("FAIL rmr_reread: got v=%b %h want 1 %h", rd_valid, rd_data, d); end
    tick();
    M_AXI_ARREADY = 1'b0;
  endtask

  task automatic test_no_last();
    logic [127:0] a, b;
    a = 128'h1; b = 128'hBBBB_0000_CCCC_0000_DDDD_0000_EEEE_0002;
    rd_addr = 27'h0000100; rd_avalid = 1'b1; rd_dready = 1'b1; M_AXI_ARREADY = 1'b1;
    tick();
    rd_avalid = 1'b0;
    tick();
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b0; M_AXI_RDATA = a;
    tick();
    n_cmp++; if ({rd_valid, M_AXI_RREADY} !== 2'b01) begin n_fail++; $display("FAIL nolast_discard: got rd_valid/rready %b want 01", {rd_valid, M_AXI_RREADY}); end
    M_AXI_RLAST = 1'b1; M_AXI_RDATA = b;
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== b) begin n_fail++; $display("FAIL nolast_data: got v=%b %h want 1 %h", rd_valid, rd_data, b); end
    tick();
  endtask

  task automatic test_resp_handling();
    int aw0, w0, ar0;
    logic [127:0] d;
    d = 128'h0BAD_0BAD_0BAD_0BAD_600D_600D_600D_600D;
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
    wr_addr = 27'h0002220; wr_data = d; wr_valid = 1'b1;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    tick();
    wr_valid = 1'b0; wr_data = '0; wr_addr = '0;
    tick();
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b10;
    tick();
`ifdef DDR_MASTER_RETRY_EN
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    n_cmp++; if ({wr_ready, M_AXI_AWVALID, M_AXI_WVALID} !== 3'b011) begin
      n_fail++; $display("FAIL retry_reissue: got wr_ready/aw/w %b want 011", {wr_ready, M_AXI_AWVALID, M_AXI_WVALID}); end
    n_cmp++; if (M_AXI_AWADDR !== 27'h0002220 || M_AXI_WDATA !== d) begin
      n_fail++; $display("FAIL retry_payload: got %h %h want 0002220 %h", M_AXI_AWADDR, M_AXI_WDATA, d); end
    tick();
    M_AXI_BVALID = 1'b1;
    tick();
    M_AXI_BVALID = 1'b0;
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL retry_done: got %b want 1", wr_ready); end
    n_cmp++; if ((aw_cnt - aw0) !== 2 || (w_cnt - w0) !== 2) begin n_fail++; $display("FAIL retry_beats: got aw=%0d w=%0d want 2 2", aw_cnt - aw0, w_cnt - w0); end
`else
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    n_cmp++; if ({wr_ready, M_AXI_AWVALID, M_AXI_WVALID} !== 3'b100) begin
      n_fail++; $display("FAIL bresp_ignored: got wr_ready/aw/w %b want 100", {wr_ready, M_AXI_AWVALID, M_AXI_WVALID}); end
    n_cmp++; if ((aw_cnt - aw0) !== 1 || (w_cnt - w0) !== 1) begin n_fail++; $display("FAIL bresp_beats: got aw=%0d w=%0d want 1 1", aw_cnt - aw0, w_cnt - w0); end
`endif
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    rd_addr = 27'h0005550; rd_avalid = 1'b1; rd_dready = 1'b1; M_AXI_ARREADY = 1'b1;
    tick();
    rd_avalid = 1'b0;
    tick();
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; M_AXI_RRESP = 2'b10; M_AXI_RDATA = d;
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
`ifdef DDR_MASTER_RETRY_EN
    n_cmp++; if ({rd_valid, M_AXI_ARVALID} !== 2'b01) begin n_fail++; $display("FAIL rretry_reissue: got rd_valid/arvalid %b want 01", {rd_valid, M_AXI_ARVALID}); end
    tick();
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1;
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== d) begin n_fail++; $display("FAIL rretry_data: got v=%b %h want 1 %h", rd_valid, rd_data, d); end
    n_cmp++; if ((ar_cnt - ar0) !== 2) begin n_fail++; $display("FAIL rretry_beats: got ar=%0d want 2", ar_cnt - ar0); end
`else
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== d || M_AXI_ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL rresp_ignored: got v=%b arvalid=%b %h want 1 0 %h", rd_valid, M_AXI_ARVALID, rd_data, d); end
    n_cmp++; if ((ar_cnt - ar0) !== 1) begin n_fail++; $display("FAIL rresp_beats: got ar=%0d want 1", ar_cnt - ar0); end
`endif
    M_AXI_ARREADY = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_zero_wait();
    test_concurrent();
    test_backpressure();
    test_reset_mid_read();
    test_no_last();
    test_resp_handling();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_line_master.md
# ddr_line_master

Bridge between the data-cache refill/eviction logic and a 128-bit AXI4 memory port (DDR2 controller). It accepts one 16-byte cache-line write (eviction) and one 16-byte cache-line read (refill) through simple valid/ready handshakes, and issues each as a single-beat AXI burst. The write and read channels run independently and concurrently. It sits between the data-memory/cache block and the DDR interconnect.

## Interface
- Parameters: none; all widths fixed.
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `wr_addr` in 27 — byte address of line to write; bits [3:0] are always 0.
- `wr_data` in 128 — line data to write.
- `wr_valid` in 1 — write request.
- `wr_ready` out 1 — write channel idle; request accepted when `wr_valid && wr_ready`.
- `rd_addr` in 27 — byte address of line to read; bits [3:0] are 0.
- `rd_avalid` in 1 — read request.
- `rd_aready` out 1 — read channel idle; request accepted when `rd_avalid && rd_aready`.
- `rd_data` out 128 — returned line.
- `rd_valid` out 1 — `rd_data` valid.
- `rd_dready` in 1 — consumer takes data when `rd_valid && rd_dready`.
- AXI4 write address: `M_AXI_AWADDR` out 27, `AWLEN` out 8, `AWSIZE` out 3, `AWBURST` out 2, `AWLOCK` out 1, `AWCACHE` out 4, `AWPROT` out 3, `AWQOS` out 4, `AWVALID` out 1, `AWREADY` in 1.
- AXI4 write data: `M_AXI_WDATA` out 128, `WSTRB` out 16, `WLAST` out 1, `WVALID` out 1, `WREADY` in 1.
- AXI4 write response: `M_AXI_BRESP` in 2, `BVALID` in 1, `BREADY` out 1.
- AXI4 read address: `M_AXI_ARADDR` out 27, `ARLEN` out 8, `ARSIZE` out 3, `ARBURST` out 2, `ARLOCK` out 2, `ARCACHE` out 4, `ARPROT` out 3, `ARQOS` out 4, `ARVALID` out 1, `ARREADY` in 1.
- AXI4 read data: `M_AXI_RDATA` in 128, `RRESP` in 2, `RLAST` in 1, `RVALID` in 1, `RREADY` out 1.

## Operation
- Constant outputs:
  - AW/AR: `LEN` = 0, `SIZE` = 3'b100 (16 B), `BURST` = 2'b01 (INCR), `LOCK` = 0, `CACHE` = 4'b0011, `PROT` = 0, `QOS` = 0.
  - W: `WSTRB` = 16'hFFFF, `WLAST` = 1.
- Write FSM has three states: W_IDLE, W_SEND, W_RESP.
  - W_IDLE: `wr_ready` = 1. On `wr_valid`, latch `wr_addr` into `AWADDR` and `wr_data` into `WDATA`, then go to W_SEND.
  - W_SEND: `AWVALID` and `WVALID` are raised together. Each drops independently on its own handshake (AW and W may complete in either order or the same cycle). When both are done, go to W_RESP.
  - W_RESP: `BREADY` = 1. On `BVALID`, go to W_IDLE.
- Read FSM has three states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: `rd_aready` = 1, and `rd_valid`, if set, stays until consumed. On `rd_avalid`, with no undelivered data, latch `rd_addr` into `ARADDR` and go to R_ADDR.
  - R_ADDR: `ARVALID` = 1. On `ARREADY`, go to R_DATA.
  - R_DATA: `RREADY` = 1. On `RVALID && RLAST`, register `RDATA` into `rd_data`, set `rd_valid`, and go to R_IDLE.
  - `rd_valid` clears on `rd_valid && rd_dready`.
  - `rd_aready` is 0 while `rd_valid` = 1.
- Write and read requests may be accepted in the same cycle. No ordering is enforced between the channels; the caller never reads and writes the same line concurrently.
- Payloads and addresses are latched on accept. The caller may change `wr_*`/`rd_addr` freely afterwards.

## Timing
- Reset values:
  - `wr_ready` = 1, `rd_aready` = 1.
  - `rd_valid` = 0, `rd_data` = 0.
  - `AWVALID`, `WVALID`, `BREADY`, `ARVALID`, `RREADY` = 0.
  - `AWADDR`, `ARADDR`, `WDATA` = 0.
  - Both FSMs go to IDLE, abandoning any in-flight transaction.
- All outputs are registered.
- `wr_ready` falls in the cycle after the accepting edge. It stays 0 until the cycle after the `BVALID && BREADY` edge. The caller relies on seeing `wr_ready` = 0 immediately after acceptance.
- `AWVALID`/`WVALID` assert the cycle after acceptance.
  - Minimum write occupancy: 1 cycle W_SEND + 1 cycle W_RESP.
- `ARVALID` asserts the cycle after read acceptance.
- `rd_valid` asserts the cycle after the `RVALID && RREADY` edge.
  - Minimum read latency: accept-to-`rd_valid` = 3 cycles with zero-wait slave.
- `RVALID` without `RLAST` (not expected, since LEN = 0) is accepted and the data discarded.

## Configuration
- Macro `DDR_MASTER_RETRY_EN`.
- Defined:
  - `BRESP != 2'b00` in W_RESP: return to W_SEND and reissue the same address and data.
  - `RRESP != 2'b00` on the last beat: discard the data, return to R_ADDR, and reissue.
- Not defined: BRESP/RRESP are ignored and responses are always treated as OKAY.

## Test plan
- Write, zero-wait slave: `wr_addr` = 27'h0001230, `wr_data` = 128'hDEADBEEF_…_01 -> AW/W issued with `AWADDR` = 27'h0001230, `WSTRB` = FFFF, `WLAST` = 1; `wr_ready` is 0 the next cycle and back to 1 the cycle after `BVALID`.
- Read, zero-wait slave: `rd_addr` = 27'h0004560, slave returns 128'h0123…CDEF -> `rd_valid` asserted 3 cycles after accept with that data; with `rd_dready` held high, `rd_valid` clears next cycle.
- Concurrent: write to 27'h10 and read from 27'h20 accepted the same cycle, `AWREADY` delayed 4 cycles -> the read completes independently; the write completes after `AWREADY`.
- Backpressure: `WREADY` before `AWREADY` by 2 cycles -> `WVALID` drops on its handshake; the FSM waits for AW, then enters W_RESP; exactly one AW and one W beat are sent.
- Reset mid-read (in R_DATA) -> all valids 0 and `rd_aready` = 1 the next cycle; a later read proceeds normally.
- With `DDR_MASTER_RETRY_EN`: first `BRESP` = 2'b10, second = 2'b00 -> the same AWADDR/WDATA is sent twice; `wr_ready` returns only after the OKAY response.
